// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128/192/256 key-schedule engine.
// Produces one 32-bit expanded-key word per cycle and packs each group of four
// words into a 128-bit round key. Round keys leave through a small FIFO.
// Optional feature macro: AES_KEY_SCHED_EQINV_EN. When it is defined, round
// keys 1..Nr-1 of a request with eqinv=1 pass through InvMixColumns, which
// gives the keys used by the equivalent inverse cipher.
//
// Handshakes: a transfer on either interface happens on a rising clock edge
// where its valid and ready are both 1 (start/start_ready, rk_valid/rk_ready).
// The producer keeps rk_data/rk_index/rk_last stable while rk_valid is 1 and
// rk_ready is 0. start_ready does not depend on start.
module aes_key_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter bit RESET_ERR  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         start_ready,
  input  logic [1:0]   key_size,
  input  logic [255:0] key,
  input  logic         eqinv,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         busy,
  output logic         err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box: multiplicative inverse (b^254, with 0 mapping to 0) then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int k = 7; k >= 0; k--) begin
      inv = gf_mul(inv, inv);
      if (k != 0) inv = gf_mul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_KEY_SCHED_EQINV_EN
  // InvMixColumns on four columns; byte 0 of each column is the word's MSB
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction
`endif

  state_t        state;
  logic [255:0]  key_q;
  logic [3:0]    nk_q;       // 4, 6 or 8 key words
  logic [3:0]    nr_q;       // 10, 12 or 14 rounds
  logic          is256_q;
  logic [7:0]    rcon;
  logic [5:0]    word_idx;   // i
  logic [2:0]    pos;        // i mod Nk
  logic [31:0]   win [8];    // win[k] = w[i-1-k]
  logic [95:0]   pk;         // packer: up to three earlier words, oldest in the top bits
  logic [1:0]    pk_cnt;
  logic [3:0]    rnd;        // round number of the key being packed

  logic [127:0]  mem_data [FIFO_DEPTH];
  logic [3:0]    mem_idx  [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   key_w [8];
  logic [2:0]    nk_m1;
  logic [31:0]   prev, rot_in, sub_w, temp, new_w;
  logic          full, pop, stall, step, push;
  logic [127:0]  push_data;
  logic [1:0]    eff_size;

`ifdef AES_KEY_SCHED_EQINV_EN
  logic          eqinv_q;
`else
  logic          unused_eqinv;
  assign unused_eqinv = eqinv;
`endif

  // Key words of the latched cipher key, MSB-aligned
  always_comb begin
    for (int k = 0; k < 8; k++) key_w[k] = key_q[255-32*k -: 32];
  end

  // Next expanded word: RotWord/SubWord/Rcon selection and XOR with w[i-Nk]
  always_comb begin
    nk_m1  = 3'(nk_q - 4'd1);
    prev   = win[0];
    rot_in = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_w  = '0;
    for (int b = 0; b < 4; b++) sub_w[8*b +: 8] = sbox(rot_in[8*b +: 8]);
    if (pos == 3'd0)                temp = sub_w ^ {rcon, 24'h0};
    else if (is256_q && pos == 3'd4) temp = sub_w;
    else                            temp = prev;
    if (word_idx < {2'b00, nk_q}) new_w = key_w[word_idx[2:0]];
    else                          new_w = win[nk_m1] ^ temp;
  end

  // Stall only when the 4th word would need a FIFO slot that is not freed this cycle
  always_comb begin
    full     = (count == CW'(FIFO_DEPTH));
    pop      = rk_valid && rk_ready;
    stall    = (pk_cnt == 2'd3) && full && !pop;
    step     = (state == S_EXPAND) && !stall;
    push     = step && (pk_cnt == 2'd3);
    eff_size = (key_size == 2'b11 && !RESET_ERR) ? 2'b00 : key_size;
    push_data = {pk, new_w};
`ifdef AES_KEY_SCHED_EQINV_EN
    if (eqinv_q && rnd != 4'd0 && rnd != nr_q) push_data = inv_mix({pk, new_w});
`endif
  end

  // Control FSM, expansion datapath and packer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      err      <= 1'b0;
      key_q    <= '0;
      nk_q     <= 4'd4;
      nr_q     <= 4'd10;
      is256_q  <= 1'b0;
      rcon     <= 8'h01;
      word_idx <= '0;
      pos      <= '0;
      pk       <= '0;
      pk_cnt   <= '0;
      rnd      <= '0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
`ifdef AES_KEY_SCHED_EQINV_EN
      eqinv_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (key_size == 2'b11 && RESET_ERR) begin
              err <= 1'b1;
            end else begin
              err      <= 1'b0;
              key_q    <= key;
              is256_q  <= (eff_size == 2'b10);
              rcon     <= 8'h01;
              word_idx <= '0;
              pos      <= '0;
              pk_cnt   <= '0;
              rnd      <= '0;
              state    <= S_EXPAND;
`ifdef AES_KEY_SCHED_EQINV_EN
              eqinv_q  <= eqinv;
`endif
              case (eff_size)
                2'b00:   begin nk_q <= 4'd4; nr_q <= 4'd10; end
                2'b01:   begin nk_q <= 4'd6; nr_q <= 4'd12; end
                default: begin nk_q <= 4'd8; nr_q <= 4'd14; end
              endcase
            end
          end
        end
        S_EXPAND: begin
          if (step) begin
            win[0] <= new_w;
            for (int k = 1; k < 8; k++) win[k] <= win[k-1];
            word_idx <= word_idx + 6'd1;
            pos      <= (pos == nk_m1) ? 3'd0 : pos + 3'd1;
            if (word_idx >= {2'b00, nk_q} && pos == 3'd0) rcon <= xtime(rcon);
            if (pk_cnt == 2'd3) begin
              pk_cnt <= 2'd0;
              rnd    <= rnd + 4'd1;
              if (rnd == nr_q) state <= S_DRAIN;
            end else begin
              pk     <= {pk[63:0], new_w};
              pk_cnt <= pk_cnt + 2'd1;
            end
          end
        end
        S_DRAIN: begin
          if (count == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_idx[wr_ptr]  <= rnd;
      mem_last[wr_ptr] <= (rnd == nr_q);
    end
  end

  assign start_ready = (state == S_IDLE);
  assign rk_valid    = (count != '0);
  assign rk_data     = rk_valid ? mem_data[rd_ptr] : '0;
  assign rk_index    = rk_valid ? mem_idx[rd_ptr]  : '0;
  assign rk_last     = rk_valid ? mem_last[rd_ptr] : 1'b0;
  assign busy        = (state != S_IDLE) || rk_valid;

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: directed bench for aes_key_sched with a FIPS-197 style
// key-expansion model (table S-box, Rcon table) feeding an expected queue.
module tb_aes_key_sched;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_size = 2'b00;
  logic [255:0] key = '0;
  logic         eqinv = 1'b0;
  logic         rk_ready = 1'b0;
  logic         start_ready, rk_valid, rk_last, busy, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_key_sched dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .key_size(key_size), .key(key), .eqinv(eqinv),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .rk_last(rk_last), .busy(busy), .err(err)
  );

  // ---------------- model ----------------
  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0] rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [31:0]  mw [60];
  logic [132:0] exp_q [$];   // {last, index, data}

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = sbox_rows[b[7:4]];
    return row[8*(15-int'(b[3:0])) +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
  endfunction

`ifdef AES_KEY_SCHED_EQINV_EN
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix_m(input logic [127:0] s);
    logic [7:0] c [4][4];
    logic [127:0] o;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++) c[col][row] = s[127-32*col-8*row -: 8];
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        o[127-32*col-8*row -: 8] = gm(c[col][row], 8'h0e) ^ gm(c[col][(row+1)%4], 8'h0b) ^
                                   gm(c[col][(row+2)%4], 8'h0d) ^ gm(c[col][(row+3)%4], 8'h09);
    return o;
  endfunction
`endif

  // Expand the key in mw[] and queue the expected round keys
  task automatic build_model(input logic [1:0] ks, input logic [255:0] k);
    int nk, nr;
    logic [31:0] t;
    logic [127:0] rk;
    nk = (ks == 2'd1) ? 6 : (ks == 2'd2) ? 8 : 4;
    nr = nk + 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) mw[i] = k[255-32*i -: 32];
      else begin
        t = mw[i-1];
        if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
        else if (nk == 8 && i % 8 == 4) t = sub_word(t);
        mw[i] = mw[i-nk] ^ t;
      end
    end
    exp_q.delete();
    for (int r = 0; r <= nr; r++) begin
      rk = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
`ifdef AES_KEY_SCHED_EQINV_EN
      if (eqinv && r > 0 && r < nr) rk = inv_mix_m(rk);
`endif
      exp_q.push_back({(r == nr), 4'(r), rk});
    end
  endtask

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int first_seen = -1;
  int last_seen = -1;
  int got = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every cycle with a key on offer: it must be the head of the expected queue
  always @(negedge clk) begin
    if (!reset && rk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rk_unexpected: got index %0d, want no key", rk_index);
      end else begin
        if ({rk_last, rk_index, rk_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL rk_stream: got last=%0b idx=%0d data=%h want %h",
                   rk_last, rk_index, rk_data, exp_q[0]);
        end
        if (rk_index == 4'd0 && first_seen < 0) first_seen = cyc;
        if (rk_last) last_seen = cyc;
        if (rk_ready) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic run_key(input logic [1:0] ks, input logic [255:0] k, input logic inv,
                         input int hold, output int c0);
    eqinv = inv;
    build_model(ks, k);
    first_seen = -1;
    last_seen = -1;
    got = 0;
    rk_ready = (hold == 0);
    key_size = ks;
    key = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    check("start_ready_low", start_ready, 1'b0);
    check("busy_high", busy, 1'b1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check("stall_valid", rk_valid, 1'b1);
      check("stall_head_idx", rk_index, 4'd0);
      check("stall_no_pop", got, 0);
    end
    rk_ready = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_done_in_budget"}, (n < budget), 1'b1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_start_ready"}, start_ready, 1'b1);
  endtask

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef00112233445566778899aabb};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hcafef00d12345678};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_rk_valid", rk_valid, 1'b0);
    check("rst_rk_data", rk_data, 128'h0);
    check("rst_rk_index", rk_index, 4'd0);
    check("rst_rk_last", rk_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // AES-128, unstalled
    run_key(2'b00, K128, 1'b0, 0, c0);
    check("m128_rk0", {mw[0], mw[1], mw[2], mw[3]}, K128[255:128]);
    check("m128_rk1", {mw[4], mw[5], mw[6], mw[7]}, 128'ha0fafe1788542cb123a339392a6c7605);
    check("m128_rk10", {mw[40], mw[41], mw[42], mw[43]}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done("aes128", 200);
    check("aes128_first_lat", first_seen - c0, 4);
    check("aes128_last_lat", last_seen - c0, 44);
    check("aes128_count", got, 11);

    // AES-192 (eqinv requested: only honoured in the equivalent-inverse build)
    run_key(2'b01, K192, 1'b1, 0, c0);
    check("m192_rk12", {mw[48], mw[49], mw[50], mw[51]}, 128'he98ba06f448c773c8ecc720401002202);
    wait_done("aes192", 200);
    check("aes192_last_lat", last_seen - c0, 52);
    check("aes192_count", got, 13);

    // AES-256
    run_key(2'b10, K256, 1'b0, 0, c0);
    check("m256_rk14", {mw[56], mw[57], mw[58], mw[59]}, 128'hfe4890d1e6188d0b046df344706c631e);
    wait_done("aes256", 200);
    check("aes256_last_lat", last_seen - c0, 60);
    check("aes256_count", got, 15);

    // AES-128 with back-pressure for 40 cycles
    run_key(2'b00, K128, 1'b0, 40, c0);
    wait_done("stall128", 300);
    check("stall128_count", got, 11);

    // Illegal key size
    key_size = 2'b11;
    key = K256;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ill_err", err, 1'b1);
    check("ill_start_ready", start_ready, 1'b1);
    check("ill_busy", busy, 1'b0);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      check("ill_no_rk", rk_valid, 1'b0);
    end
    run_key(2'b00, K128, 1'b0, 0, c0);
    check("ill_err_cleared", err, 1'b0);
    wait_done("after_ill", 200);
    check("after_ill_count", got, 11);

    // Reset in the middle of an AES-256 run
    run_key(2'b10, K256, 1'b0, 0, c0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_at_e20", cyc - c0, 20);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_rk_valid", rk_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_start_ready", start_ready, 1'b1);
    check("midrst_rk_index", rk_index, 4'd0);
    check("midrst_rk_data", rk_data, 128'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_key(2'b00, K128, 1'b0, 0, c0);
    wait_done("post_rst", 200);
    check("post_rst_count", got, 11);
    check("post_rst_last_lat", last_seen - c0, 44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
- Iterative, parametrised AES key-schedule engine: one block serves AES-128, AES-192 and AES-256, with the key size selected per request at run time.
- Expands the cipher key one 32-bit word per cycle and packs the words into 128-bit round keys.
- Round keys are delivered in order through a buffered valid/ready stream to iterative round engines.
- Replaces the fixed-size, fully unrolled key expansion with a small-area, back-pressure-aware generator.

Parameters:
- FIFO_DEPTH, 4, round-key output buffer depth in 128-bit entries; power of two, >=2.
- RESET_ERR, 1, if 1, a start with an illegal key_size sets err; if 0, key_size 2'b11 is treated as 2'b00 (AES-128).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request valid
- start_ready  out  1  engine idle and able to accept a request
- key_size  in  2  00=128, 01=192, 10=256, 11=illegal
- key  in  256  cipher key, MSB-aligned; for 128/192 the low bits are ignored
- eqinv  in  1  request equivalent-inverse round keys (AES_KEY_SCHED_EQINV_EN only)
- rk_valid  out  1  round key available
- rk_ready  in  1  consumer accepts round key
- rk_data  out  128  round key, w[4r] in bits 127:96
- rk_index  out  4  round number r, 0..Nr
- rk_last  out  1  rk_index==Nr
- busy  out  1  expansion in progress or FIFO non-empty
- err  out  1  sticky illegal-key_size flag; cleared by the next legal start

Behaviour:
- Constants: Nk=4/6/8 and Nr=10/12/14 for 128/192/256; total words 4*(Nr+1) = 44/52/60.
- States:
  - IDLE: start_ready=1. Start accepted when start&&start_ready. Latch key, key_size, eqinv; rcon=8'h01; i=0. Go to EXPAND.
  - Illegal size with RESET_ERR=1: set err, no keys produced, stay in IDLE.
  - EXPAND: one word w[i] per unstalled cycle.
    - i<Nk: w[i] is the latched key word.
    - Otherwise w[i] = w[i-Nk] ^ temp.
    - temp = SubWord(RotWord(w[i-1]))^{rcon,24'h0} if i%Nk==0, and rcon <= xtime(rcon) on that cycle.
    - temp = SubWord(w[i-1]) if Nk==8 and i%8==4.
    - temp = w[i-1] otherwise.
    - Window: 8-word shift register. S-boxes are combinational, 4 instances.
  - Packer collects 4 words. On the 4th word, push {w[4r..4r+3]} with index r into the FIFO.
  - Stall: hold i, rcon, window and packer while the packer holds 3 words and the FIFO is full.
  - After pushing r==Nr, go to DRAIN.
  - DRAIN: wait for FIFO empty, then go to IDLE. start_ready stays 0 throughout EXPAND and DRAIN.
- Latency, unstalled: start accepted at edge E0; words at E1..E4; rk 0 pushed at E4; rk_valid=1 in the cycle after E4.
- Round key r is pushed at edge E(4r+4). With rk_ready held at 1, keys appear on consecutive 4-cycle boundaries.
- The last key is pushed at E44, E52 or E60.
- FIFO:
  - rk_data, rk_index and rk_last are driven from the head entry.
  - Pop when rk_valid&&rk_ready.
  - Push and pop in the same cycle when full is permitted, since the pop frees the slot.
  - Output fields are held stable while rk_valid&&!rk_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- rk_index increases monotonically 0..Nr with no gaps. rk_last=1 only with rk_index==Nr.
- Reset values: state IDLE, FIFO empty, start_ready=1, rk_valid=0, rk_data=0, rk_index=0, rk_last=0, busy=0, err=0.
- Reset mid-operation: everything returns to reset values immediately and buffered keys are discarded.
- start while busy: ignored, because start_ready=0.
- A start in the same cycle as the DRAIN->IDLE transition: not accepted; start_ready rises the next cycle.

Optional Feature:
- Macro: AES_KEY_SCHED_EQINV_EN.
- Defined: when the latched eqinv=1, round keys 1..Nr-1 pass through InvMixColumns (per column) before the FIFO push. Keys 0 and Nr are unchanged.
- Defined: the order is still 0..Nr; the consumer reverses it. Adds no latency.
- Undefined: no InvMixColumns logic is present and the eqinv input is ignored.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> 11 keys; rk0 equals the key; rk1=a0fafe1788542cb123a339392a6c7605; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1; done at E44.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 keys; rk12=e98ba06f448c773c8ecc720401002202; rk_index 0..12 contiguous.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 keys; rk14=fe4890d1e6188d0b046df344706c631e.
- AES-128 with rk_ready=0 for 40 cycles -> FIFO fills to FIFO_DEPTH, expansion stalls, rk_data held stable; after release, all 11 keys arrive correct, in order, none lost or duplicated.
- key_size=2'b11 with RESET_ERR=1 -> err=1, no rk_valid, start_ready=1 next cycle; a following legal start clears err.
- Reset asserted at E20 of an AES-256 run -> rk_valid=0 and busy=0 immediately; a new AES-128 run then produces correct keys.
